// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 oversampling receiver feeding a
// first-word-fall-through byte FIFO for the command parser.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 1736,
  parameter int DEPTH        = 16
) (
  input  logic       CLK100MHZ,
  input  logic       RESET_N,
  input  logic       Uart_RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow,
  input  logic       overflow_clr,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic          rxd_m, rxd_s, rxd_p;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          push_q;
  logic          cnt_clr, shift_en, stop_ok, stop_bad;
  logic          at_last, at_half;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          pop, full, wr, drop;

  assign at_last = (cnt == LAST);
  assign at_half = (cnt == HALF);

  // two-flop synchroniser plus one history flop for edge detect
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= Uart_RXD;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  // receiver state register
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_n;
  end

  // receiver next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (rxd_p & ~rxd_s) state_n = START;
      START:     if (at_half) state_n = rxd_s ? IDLE : DATA;
      DATA:      if (at_last && idx == 3'd7) state_n = STOP;
      STOP:      if (at_last) state_n = rxd_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxd_s) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // receiver decode of counter/shift/stop strobes
  always_comb begin
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (1'b1)
      (state == IDLE):      cnt_clr = 1'b1;
      (state == START):     cnt_clr = at_half;
      (state == DATA): begin
        cnt_clr  = at_last;
        shift_en = at_last;
      end
      (state == STOP): begin
        cnt_clr  = at_last;
        stop_ok  = at_last & rxd_s;
        stop_bad = at_last & ~rxd_s;
      end
      (state == WAIT_HIGH): cnt_clr = 1'b1;
      default:              cnt_clr = 1'b1;
    endcase
  end

  // bit timing, LSB-first shifter and registered strobes
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;
      push_q    <= stop_ok;
      frame_err <= stop_bad;
      if (state == START) idx <= '0;
      else if (shift_en)  idx <= idx + 1'b1;
      if (shift_en) sh <= {rxd_s, sh[7:1]};
    end
  end

  assign busy     = (state != IDLE);
  assign rx_valid = (count != '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop      = rx_valid & rx_ready;
  assign wr       = push_q & (~full | pop);
  assign drop     = push_q & full & ~pop;
  assign rx_data  = rx_valid ? mem[rptr] : 8'h00;

  // FIFO storage
  always_ff @(posedge CLK100MHZ) begin
    if (wr) mem[wptr] <= sh;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo with
// directed scenarios followed by a randomized traffic phase.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overflow, busy;

  int         total = 0;
  int         bad = 0;
  int         fe_seen = 0;
  int         fe_exp = 0;
  int         vld_cycles = 0;
  logic [7:0] exp_q [$];
  bit         rdone;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .CLK100MHZ   (clk),
    .RESET_N     (rst_n),
    .Uart_RXD    (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .overflow_clr(overflow_clr),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_head(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input bit expect_push, input int low_extra);
    if (expect_push) exp_q.push_back(b);
    if (!stop) fe_exp++;
    send_head(b, stop);
    tick(CPB);
    if (!stop) tick(CPB * low_extra);
    rxd = 1'b1;
  endtask

  task automatic wait_busy(input logic val, input string name);
    int n;
    n = 0;
    while (busy !== val && n < CPB * 20) begin
      tick(1);
      n++;
    end
    check(name, busy, val);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_valid"}, rx_valid, 0);
    check({tag, "_data"}, rx_data, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // monitor: pops the scoreboard whenever the DUT hands over a byte
  initial begin
    logic [7:0] prev_data;
    bit         prev_hold;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_err) fe_seen++;
        if (rx_valid) vld_cycles++;
        if (prev_hold && rx_valid) check("hold", rx_data, prev_data);
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop: got %0h want nothing", rx_data);
          end else begin
            check("pop", rx_data, exp_q.pop_front());
          end
        end
        prev_hold = rx_valid & ~rx_ready;
        prev_data = rx_data;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fe0;
    int n;
    logic [7:0] b3c;
    b3c = 8'h3C;

    tick(3);
    check_reset_outs("rst_hold");
    rst_n = 1'b1;
    tick(3);
    check_reset_outs("rst_rel");

    rx_ready = 1'b1;
    vld_cycles = 0;
    send_byte(8'h23, 1'b1, 1'b1, 0);
    tick(CPB);
    check("single_vld_cycles", vld_cycles, 1);
    check("single_ferr", fe_seen, 0);
    check("single_q", exp_q.size(), 0);

    rx_ready = 1'b0;
    send_byte(8'h23, 1'b1, 1'b1, 0);
    send_byte(8'h31, 1'b1, 1'b1, 0);
    send_byte(8'h0D, 1'b1, 1'b1, 0);
    send_byte(8'h0A, 1'b1, 1'b1, 0);
    tick(4);
    check("burst_count", dut.count, 4);
    rx_ready = 1'b1;
    tick(4);
    check("burst_drained", rx_valid, 0);
    check("burst_q", exp_q.size(), 0);

    rx_ready = 1'b0;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    check("glitch_busy_hi", busy, 1);
    wait_busy(1'b0, "glitch_busy_lo");
    tick(4);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", fe_seen, 0);

    rx_ready = 1'b1;
    fe0 = fe_seen;
    send_byte(8'h55, 1'b0, 1'b0, 3);
    tick(4);
    send_byte(8'hAA, 1'b1, 1'b1, 0);
    tick(CPB);
    check("ferr_pulses", fe_seen - fe0, 1);
    check("ferr_q", exp_q.size(), 0);
    check("ferr_valid", rx_valid, 0);

    rx_ready = 1'b0;
    for (int i = 0; i < 17; i++)
      send_byte(8'(i), 1'b1, i < DEPTH, 0);
    tick(4);
    check("ovf_set", overflow, 1);
    check("ovf_count", dut.count, DEPTH);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    exp_q.push_back(8'h77);
    send_head(8'h77, 1'b1);
    n = 0;
    while (busy && n < CPB * 4) begin
      tick(1);
      n++;
    end
    check("fullpop_idle", busy, 0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("fullpop_ovf", overflow, 0);
    check("fullpop_count", dut.count, DEPTH);
    tick(CPB);
    rx_ready = 1'b1;
    tick(DEPTH + 2);
    check("fullpop_q", exp_q.size(), 0);
    check("fullpop_valid", rx_valid, 0);

    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = b3c[i];
      tick(CPB);
    end
    rxd = b3c[4];
    tick(CPB / 2);
    check("midrst_busy", busy, 1);
    rst_n = 1'b0;
    rxd = 1'b1;
    tick(2);
    check_reset_outs("midrst");
    rst_n = 1'b1;
    tick(CPB * 2);
    check("midrst_idle", busy, 0);
    send_byte(8'hC3, 1'b1, 1'b1, 0);
    tick(CPB);
    check("midrst_q", exp_q.size(), 0);

    rdone = 1'b0;
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          logic st;
          st = ($urandom_range(0, 5) != 0);
          send_byte(8'($urandom), st, st, st ? 0 : $urandom_range(0, 2));
          tick($urandom_range(2, CPB));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          rx_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    rx_ready = 1'b1;
    tick(DEPTH + 4);
    check("rand_q", exp_q.size(), 0);
    check("rand_ferr", fe_seen, fe_exp);
    check("rand_ovf", overflow, 0);
    check("rand_valid", rx_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
